// File: rtl/raw_rgb_demosaic_2x2.sv
// Bayer 2x2 window to RGB converter: binned (one pixel per 2x2 cell) or full-resolution
// sliding window. Mode and Bayer phase are frozen at each armed frame start.
module raw_rgb_demosaic_2x2 #(
   parameter int DW    = 12,
   parameter int ROUND = 1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          FVAL,
   input  logic          DVAL,
   input  logic [DW-1:0] D0,
   input  logic [DW-1:0] D1,
   input  logic [1:0]    BAYER_PAT,
   input  logic          MODE,
   output logic [DW-1:0] R,
   output logic [DW-1:0] G,
   output logic [DW-1:0] B,
   output logic          OUT_DVAL,
   output logic          OUT_FVAL
);

   localparam logic [DW:0] L_RND = (DW+1)'(ROUND);

   // One extra sum bit so two full-scale greens never wrap before the halving.
   function automatic logic [DW-1:0] f_avg(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0] s;
      s = {1'b0, a} + {1'b0, b} + L_RND;
      return s[DW:1];
   endfunction

   logic          r_armed;
   logic          r_active;
   logic          r_fval_d;
   logic          r_dval_d;
   logic          r_mode_q;
   logic [1:0]    r_pat_q;
   logic [DW-1:0] r_d0;
   logic [DW-1:0] r_d1;
   logic          r_xp;
   logic          r_yp;
   logic          r_first_row;
   logic          r_first_col;
   logic [DW-1:0] r_r;
   logic [DW-1:0] r_g;
   logic [DW-1:0] r_b;
   logic          r_out_dval;

   logic          w_dval;
   logic          w_rise;
   logic          w_emit;
   logic [1:0]    w_q;
   logic [DW-1:0] w_r;
   logic [DW-1:0] w_g;
   logic [DW-1:0] w_b;

   assign w_dval = DVAL & FVAL;
   assign w_rise = FVAL & ~r_fval_d & r_armed;
   assign w_q    = {r_yp ^ r_pat_q[1], r_xp ^ r_pat_q[0]};

   // Colour selection from the 2x2 window and the emit decision for this beat.
   always_comb begin
      w_r = D0;
      w_g = f_avg(D1, r_d0);
      w_b = r_d1;
      case (w_q)
         2'b00: begin
            w_r = D0;
            w_b = r_d1;
            w_g = f_avg(D1, r_d0);
         end
         2'b01: begin
            w_r = r_d0;
            w_b = D1;
            w_g = f_avg(D0, r_d1);
         end
         2'b10: begin
            w_r = D1;
            w_b = r_d0;
            w_g = f_avg(D0, r_d1);
         end
         2'b11: begin
            w_r = r_d1;
            w_b = D0;
            w_g = f_avg(D1, r_d0);
         end
         default: begin
            w_r = D0;
            w_b = r_d1;
            w_g = f_avg(D1, r_d0);
         end
      endcase
      if (r_mode_q) begin
         w_emit = w_dval & r_active & ~r_first_col & ~r_first_row;
      end else begin
         w_emit = w_dval & r_active & r_xp & r_yp;
      end
   end

   // Frame arming, frame-active flag and per-frame latch of mode and phase.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_armed  <= 1'b0;
         r_active <= 1'b0;
         r_fval_d <= 1'b0;
         r_mode_q <= 1'b0;
         r_pat_q  <= 2'b00;
      end else begin
         r_fval_d <= FVAL;
         if (!FVAL) begin
            r_armed <= 1'b1;
         end
         if (w_rise) begin
            r_active <= 1'b1;
            r_mode_q <= MODE;
            r_pat_q  <= BAYER_PAT;
         end else if (!FVAL) begin
            r_active <= 1'b0;
         end
      end
   end

   // Column/row parity and first-row/first-column flags derived from FVAL/DVAL.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_xp        <= 1'b0;
         r_yp        <= 1'b0;
         r_first_row <= 1'b0;
         r_first_col <= 1'b0;
         r_dval_d    <= 1'b0;
      end else if (!FVAL) begin
         r_xp        <= 1'b0;
         r_yp        <= 1'b0;
         r_first_row <= 1'b1;
         r_first_col <= 1'b1;
         r_dval_d    <= 1'b0;
      end else begin
         r_dval_d <= DVAL;
         if (DVAL) begin
            r_xp        <= ~r_xp;
            r_first_col <= 1'b0;
         end else begin
            r_xp        <= 1'b0;
            r_first_col <= 1'b1;
         end
         if (!DVAL && r_dval_d) begin
            r_yp        <= ~r_yp;
            r_first_row <= 1'b0;
         end
      end
   end

   // Previous-column taps of both lines.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_d0 <= '0;
         r_d1 <= '0;
      end else if (w_dval) begin
         r_d0 <= D0;
         r_d1 <= D1;
      end
   end

   // Registered RGB outputs; colour holds between strobes.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_r        <= '0;
         r_g        <= '0;
         r_b        <= '0;
         r_out_dval <= 1'b0;
      end else if (w_emit) begin
         r_r        <= w_r;
         r_g        <= w_g;
         r_b        <= w_b;
         r_out_dval <= 1'b1;
      end else begin
         r_out_dval <= 1'b0;
      end
   end

   assign R        = r_r;
   assign G        = r_g;
   assign B        = r_b;
   assign OUT_DVAL = r_out_dval;
   assign OUT_FVAL = r_fval_d;

endmodule

// File: tb/tb_raw_rgb_demosaic_2x2.sv
// Directed bench for raw_rgb_demosaic_2x2: arming, bin/full modes, Bayer phase,
// green rounding (ROUND=1 and ROUND=0 instances), per-frame mode latch, mid-frame reset.
module tb_raw_rgb_demosaic_2x2;

   logic        CLK;
   logic        RST_N;
   logic        FVAL;
   logic        DVAL;
   logic [11:0] D0;
   logic [11:0] D1;
   logic [1:0]  BAYER_PAT;
   logic        MODE;
   logic [11:0] R, G, B;
   logic        OUT_DVAL, OUT_FVAL;
   logic [11:0] R0, G0, B0;
   logic        OUT_DVAL0, OUT_FVAL0;

   raw_rgb_demosaic_2x2 #(.DW(12), .ROUND(1)) dut (
      .CLK(CLK), .RST_N(RST_N), .FVAL(FVAL), .DVAL(DVAL), .D0(D0), .D1(D1),
      .BAYER_PAT(BAYER_PAT), .MODE(MODE), .R(R), .G(G), .B(B),
      .OUT_DVAL(OUT_DVAL), .OUT_FVAL(OUT_FVAL)
   );

   raw_rgb_demosaic_2x2 #(.DW(12), .ROUND(0)) dut0 (
      .CLK(CLK), .RST_N(RST_N), .FVAL(FVAL), .DVAL(DVAL), .D0(D0), .D1(D1),
      .BAYER_PAT(BAYER_PAT), .MODE(MODE), .R(R0), .G(G0), .B(B0),
      .OUT_DVAL(OUT_DVAL0), .OUT_FVAL(OUT_FVAL0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [11:0] mem [0:3][0:3];
   int          n_chk, n_pass, n_fail;
   int          n_pulse;
   int          cur_row, cur_col, last_row, last_col;
   logic [11:0] cap_r [0:63];
   logic [11:0] cap_g [0:63];
   logic [11:0] cap_b [0:63];
   logic [11:0] cap_g0 [0:63];
   int          cap_row [0:63];
   int          cap_col [0:63];
   logic [11:0] snap_r, snap_g, snap_b;
   logic        snap_dv, snap_fv;
   logic [11:0] er, eg, eb;

   // Capture every strobe together with the input beat that produced it.
   always @(negedge CLK) begin
      if (OUT_DVAL && n_pulse < 64) begin
         cap_r[n_pulse]   = R;
         cap_g[n_pulse]   = G;
         cap_b[n_pulse]   = B;
         cap_g0[n_pulse]  = G0;
         cap_row[n_pulse] = last_row;
         cap_col[n_pulse] = last_col;
         n_pulse++;
      end
      last_row = DVAL ? cur_row : -1;
      last_col = DVAL ? cur_col : -1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic fv, input logic dv, input logic [11:0] d0,
                        input logic [11:0] d1, input int row, input int col);
      FVAL = fv; DVAL = dv; D0 = d0; D1 = d1; cur_row = row; cur_col = col;
      @(posedge CLK); #1;
   endtask

   task automatic send_frame(input int w, input int h, input int lead,
                             input int mode_row, input int rst_row);
      for (int i = 0; i < lead; i++) drive(1'b0, 1'b0, 12'd0, 12'd0, -1, -1);
      drive(1'b1, 1'b0, 12'd0, 12'd0, -1, -1);
      for (int r = 0; r < h; r++) begin
         if (r == mode_row) MODE = ~MODE;
         if (r == rst_row) begin
            RST_N = 1'b0;
            #2;
            snap_r = R; snap_g = G; snap_b = B; snap_dv = OUT_DVAL; snap_fv = OUT_FVAL;
            RST_N = 1'b1;
         end
         for (int c = 0; c < w; c++)
            drive(1'b1, 1'b1, mem[r][c], (r > 0) ? mem[r-1][c] : 12'd0, r, c);
         drive(1'b1, 1'b0, 12'd0, 12'd0, -1, -1);
         drive(1'b1, 1'b0, 12'd0, 12'd0, -1, -1);
      end
      drive(1'b0, 1'b0, 12'd0, 12'd0, -1, -1);
      drive(1'b0, 1'b0, 12'd0, 12'd0, -1, -1);
   endtask

   // RGGB layout: R at even/even, Gr even/odd, Gb odd/even, B odd/odd.
   task automatic fill_uniform(input logic [11:0] vr, input logic [11:0] vgr,
                               input logic [11:0] vgb, input logic [11:0] vb);
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++)
            mem[y][x] = (y % 2 == 0) ? ((x % 2 == 0) ? vr : vgr) : ((x % 2 == 0) ? vgb : vb);
   endtask

   // Reference colours from site positions: R site matches the pattern in both axes,
   // B mismatches in both, the other two are green (averaged, round half up).
   task automatic model(input int r, input int c, input logic [1:0] pat);
      int gs, y, x;
      logic ry, rx;
      gs = 0;
      for (int dy = 0; dy < 2; dy++)
         for (int dx = 0; dx < 2; dx++) begin
            y  = r - 1 + dy;
            x  = c - 1 + dx;
            ry = ((y % 2) == int'(pat[1]));
            rx = ((x % 2) == int'(pat[0]));
            if (ry && rx) er = mem[y][x];
            else if (!ry && !rx) eb = mem[y][x];
            else gs = gs + int'(mem[y][x]);
         end
      eg = 12'((gs + 1) / 2);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_fail = 0; n_pulse = 0;
      cur_row = -1; cur_col = -1; last_row = -1; last_col = -1;
      RST_N = 1'b0; FVAL = 1'b1; DVAL = 1'b0; D0 = 12'd0; D1 = 12'd0;
      BAYER_PAT = 2'b00; MODE = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_R", 32'(R), 32'd0);
      check("rst_G", 32'(G), 32'd0);
      check("rst_B", 32'(B), 32'd0);
      check("rst_OUT_DVAL", 32'(OUT_DVAL), 32'd0);
      check("rst_OUT_FVAL", 32'(OUT_FVAL), 32'd0);

      // Released with FVAL high: this frame is not armed.
      RST_N = 1'b1;
      fill_uniform(12'd100, 12'd200, 12'd300, 12'd400);
      n_pulse = 0;
      send_frame(4, 4, 0, -1, -1);
      check("unarmed_count", 32'(n_pulse), 32'd0);

      // RGGB bin.
      n_pulse = 0;
      send_frame(4, 4, 2, -1, -1);
      check("bin_rggb_count", 32'(n_pulse), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("bin_rggb_R", 32'(cap_r[i]), 32'd100);
         check("bin_rggb_G", 32'(cap_g[i]), 32'd250);
         check("bin_rggb_B", 32'(cap_b[i]), 32'd400);
         check("bin_rggb_row", 32'(cap_row[i]), 32'(1 + 2 * (i / 2)));
         check("bin_rggb_col", 32'(cap_col[i]), 32'(1 + 2 * (i % 2)));
      end

      // Same data read as BGGR.
      BAYER_PAT = 2'b11;
      n_pulse = 0;
      send_frame(4, 4, 2, -1, -1);
      check("bin_bggr_count", 32'(n_pulse), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("bin_bggr_R", 32'(cap_r[i]), 32'd400);
         check("bin_bggr_G", 32'(cap_g[i]), 32'd250);
         check("bin_bggr_B", 32'(cap_b[i]), 32'd100);
      end

      // Full resolution, distinct pixels, RGGB.
      BAYER_PAT = 2'b00;
      MODE = 1'b1;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++)
            mem[y][x] = 12'(100 * y + 7 * x + 3);
      n_pulse = 0;
      send_frame(4, 4, 2, -1, -1);
      check("full_count", 32'(n_pulse), 32'd9);
      for (int i = 0; i < 9; i++) begin
         check("full_row", 32'(cap_row[i]), 32'(1 + i / 3));
         check("full_col", 32'(cap_col[i]), 32'(1 + i % 3));
         model(1 + i / 3, 1 + i % 3, 2'b00);
         check("full_R", 32'(cap_r[i]), 32'(er));
         check("full_G", 32'(cap_g[i]), 32'(eg));
         check("full_B", 32'(cap_b[i]), 32'(eb));
      end

      // Green rounding at full scale: Gr=4095 (D1), Gb=4094 (rD0).
      MODE = 1'b0;
      mem[0][0] = 12'd10; mem[0][1] = 12'd4095; mem[1][0] = 12'd4094; mem[1][1] = 12'd20;
      n_pulse = 0;
      send_frame(2, 2, 2, -1, -1);
      check("rnd_count", 32'(n_pulse), 32'd1);
      check("rnd_G_round1", 32'(cap_g[0]), 32'd4095);
      check("rnd_G_round0", 32'(cap_g0[0]), 32'd4094);
      check("rnd_R", 32'(cap_r[0]), 32'd10);
      check("rnd_B", 32'(cap_b[0]), 32'd20);
      mem[1][0] = 12'd4095;
      n_pulse = 0;
      send_frame(2, 2, 2, -1, -1);
      check("max_G_round1", 32'(cap_g[0]), 32'd4095);
      check("max_G_round0", 32'(cap_g0[0]), 32'd4095);

      // MODE flipped to bin mid-frame: frame stays full, next frame is bin.
      fill_uniform(12'd100, 12'd200, 12'd300, 12'd400);
      MODE = 1'b1;
      n_pulse = 0;
      send_frame(4, 4, 2, 2, -1);
      check("mode_mid_count", 32'(n_pulse), 32'd9);
      n_pulse = 0;
      send_frame(4, 4, 2, -1, -1);
      check("mode_next_count", 32'(n_pulse), 32'd4);

      // Reset at start of row 2 of a bin frame: only the row-1 pulses survive.
      n_pulse = 0;
      send_frame(4, 4, 2, -1, 2);
      check("midrst_R", 32'(snap_r), 32'd0);
      check("midrst_G", 32'(snap_g), 32'd0);
      check("midrst_B", 32'(snap_b), 32'd0);
      check("midrst_OUT_DVAL", 32'(snap_dv), 32'd0);
      check("midrst_OUT_FVAL", 32'(snap_fv), 32'd0);
      check("midrst_count", 32'(n_pulse), 32'd2);
      n_pulse = 0;
      send_frame(4, 4, 2, -1, -1);
      check("after_rst_count", 32'(n_pulse), 32'd4);
      check("after_rst_R", 32'(cap_r[3]), 32'd100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/raw_rgb_demosaic_2x2.md
Name: raw_rgb_demosaic_2x2

Overview:
- Parametrised Bayer-to-RGB converter that sits between the sensor line buffer (two line taps) and the RGB frame-write path.
- Generates its own row/column parity from FVAL/DVAL.
- Bayer phase is programmable.
- Two modes: 2x2 binning (quarter-rate output) or full-resolution 2x2 demosaic.
- Green average is full-precision and rounded; mode and phase are latched per frame.

Parameters:
- DW, 12, pixel width of raw input and of each RGB output channel.
- ROUND, 1, 1 = green average rounds half up; 0 = truncates.

Ports:
- CLK  in  1  pixel clock.
- RST_N  in  1  asynchronous active-low reset.
- FVAL  in  1  frame valid.
- DVAL  in  1  pixel valid within line; the low gap between lines marks end of line.
- D0  in  DW  current-line pixel.
- D1  in  DW  same-column pixel from previous line (line-buffer tap).
- BAYER_PAT  in  2  position {row,col} of the R site within the 2x2 cell (00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR).
- MODE  in  1  0 = bin, 1 = full-resolution demosaic.
- R  out  DW  red.
- G  out  DW  green.
- B  out  DW  blue.
- OUT_DVAL  out  1  RGB valid strobe.
- OUT_FVAL  out  1  FVAL delayed one cycle.

Behaviour:
- Reset: R, G, B, OUT_DVAL, OUT_FVAL = 0. Internal taps rD0/rD1, counters, flags and latched mode/pattern = 0. armed = 0.
- Arming:
  - armed sets on the first cycle FVAL = 0 after reset.
  - Frames are processed only when FVAL rises while armed = 1.
  - A reset mid-frame therefore drops the remainder of that frame.
- Frame start (FVAL 0->1 while armed): latch MODE into mode_q and BAYER_PAT into pat_q. Changes mid-frame have no effect until the next frame.
- While FVAL = 0:
  - xp = 0, yp = 0, first_row = 1, first_col = 1.
  - OUT_DVAL = 0.
- Taps: on each DVAL = 1 cycle, rD0 <= D0 and rD1 <= D1. Taps hold when DVAL = 0.
- Column parity:
  - xp toggles after each DVAL beat.
  - xp clears, and first_col sets, on any DVAL = 0 cycle.
  - first_col clears after the first beat of a line.
- Row parity: on a DVAL 1->0 edge inside the frame, yp toggles and first_row clears.
- Window for the current beat: TL = rD1, TR = D1, BL = rD0, BR = D0. Let q = {yp ^ pat_q[1], xp ^ pat_q[0]}.
  - q = 00: R = D0, B = rD1, G = avg(D1, rD0).
  - q = 01: R = rD0, B = D1, G = avg(D0, rD1).
  - q = 10: R = D1, B = rD0, G = avg(D0, rD1).
  - q = 11: R = rD1, B = D0, G = avg(D1, rD0).
- avg(a,b):
  - Sum computed in DW+1 bits (no overflow).
  - Result = (a + b + ROUND) >> 1, truncated to DW.
  - Maximum input 2^DW-1 gives 2^DW-1.
- Emit condition, evaluated on a DVAL = 1 cycle inside an armed frame:
  - mode_q = 0: xp = 1 and yp = 1.
  - mode_q = 1: first_col = 0 and first_row = 0.
- Latency: one cycle. On an emit beat, R/G/B and OUT_DVAL = 1 appear on the next clock.
- R/G/B hold their last values on non-emit cycles. OUT_DVAL = 0 on non-emit cycles.
- Output counts for a W x H frame, W and H even:
  - bin mode: (W/2)*(H/2) pixels.
  - full mode: (W-1)*(H-1) pixels.
- Odd W or H: trailing column/row produces no bin output. No error is flagged.
- FVAL dropping mid-line: DVAL is gated, OUT_DVAL = 0 from the next cycle, and counters clear.
- DVAL gaps inside a line are not supported. Any DVAL = 0 cycle is treated as end of line.

Test Plan:
- Reset release with FVAL = 1 then a 4x4 frame -> zero OUT_DVAL pulses. The next frame after an FVAL low gap is processed.
- RGGB, bin, 4x4 frame where R=100, Gr=200, Gb=300, B=400 everywhere -> 4 pulses, each R=100, G=250, B=400, one cycle after the odd-row/odd-col input.
- Same frame, BAYER_PAT = 11 (BGGR) -> 4 pulses with R=400, G=250, B=100.
- Full mode, 4x4 frame -> exactly 9 pulses. None on row 0 or column 0 beats. Colour assignment correct for all four q values.
- Green rounding: D1=4095, rD0=4094, ROUND=1 -> G=4095. Same with ROUND=0 -> G=4094. With D1=rD0=4095 -> G=4095 (no wrap).
- MODE toggled mid-frame -> output count unchanged for that frame. New mode applies from the next FVAL rise. RST_N pulsed mid-frame -> all outputs 0 immediately and no output until the next armed frame.
